timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped down-counting timer on the CPU's peripheral bus.
- Its IRQ output drives one bit of the HWInt[7:2] vector consumed by the coprocessor-0 interrupt logic.
- Software programs it through loads and stores. It produces either a one-shot held interrupt or a periodic one-cycle interrupt pulse.

Parameters:
- PRESCALE_W, 8, width of the prescaler divisor field; only used when TC_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Addr  in  [3:2]  register select: 0=CTRL, 1=PRESET, 2=COUNT.
- WE  in  1  bus write enable, sampled at posedge clk.
- Din  in  32  bus write data.
- Dout  out  32  bus read data, combinational on Addr.
- IRQ  out  1  interrupt request to the HWInt vector.

Behaviour:
- Registers:
  - CTRL: bit[0] Enable, bits[2:1] Mode, bit[3] IM (interrupt mask); bits[31:4] read as 0.
  - PRESET: 32-bit read/write.
  - COUNT: 32-bit, read-only; writes to it are ignored.
  - Addr=3 reads 0.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. IRQ=0 while reset is asserted. Dout reflects the cleared registers.
- IRQ = irq_flag & CTRL.IM, driven combinationally from registered state.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable=1 → LOAD.
  - LOAD: COUNT<=PRESET; → CNT.
  - CNT:
    - if Enable=0 → IDLE, COUNT held.
    - else if COUNT>1 → COUNT<=COUNT-1.
    - else (COUNT<=1) → COUNT<=0, irq_flag<=1, → INT.
  - INT:
    - Mode=0 (one-shot): Enable<=0; → IDLE; irq_flag stays 1.
    - Mode=1 (periodic): irq_flag<=0; → LOAD.
    - Mode=2/3: treated as Mode=0.
- Timing:
  - PRESET=P≥1, Enable written at edge E0: LOAD at E1, COUNT=P at E2, COUNT=0 with IRQ high at E2+P.
  - Mode=1 period: P+2 cycles; IRQ pulse width exactly 1 cycle.
- irq_flag clear: in Mode 0 it is cleared by any bus write to CTRL or PRESET; otherwise it holds until reset.
- Simultaneous events:
  - A bus write to CTRL takes effect at the same edge as the FSM update. If the FSM also clears Enable in INT, the bus write wins.
  - A bus write in the same edge as irq_flag<=1 (CNT→INT): the set wins.
- PRESET written during CNT does not affect the running COUNT; it is used at the next LOAD.
- PRESET=0 behaves as PRESET=1: COUNT<=0 at LOAD, INT on the following edge.
- Clearing Enable while in CNT pauses counting. Setting it again goes IDLE→LOAD, which reloads from PRESET; a paused count does not resume.
- Reset mid-count: immediate return to IDLE with all registers cleared; no spurious IRQ after release.
- COUNT arithmetic is unsigned 32-bit with no wrap: decrement only when COUNT>1.

Optional Feature:
- TC_PRESCALE_EN defined:
  - CTRL bits[4+PRESCALE_W-1:4] hold divisor D (read/write, reset 0).
  - In CNT, COUNT decrements only on ticks: an internal prescaler counts 0..D and ticks when it reaches D, so D=0 ticks every cycle.
  - The prescaler resets to 0 in LOAD and IDLE.
  - Mode=1 period becomes P·(D+1)+2 cycles.
- TC_PRESCALE_EN not defined: no prescaler logic; those CTRL bits read 0 and ignore writes; tick every cycle.

Test Plan:
- Reset held low, pulse clk → Dout=0 for Addr 0/1/2, IRQ=0; release reset → still 0.
- Write PRESET=3, then CTRL=0x9 (Enable, Mode0, IM) at E0 → COUNT=3 at E2, 2 at E3, 1 at E4, 0 at E5 with IRQ=1. IRQ stays 1 and CTRL reads 0x8 from E6. Write CTRL=0x8 → IRQ=0.
- PRESET=2, CTRL=0xB (Mode1) → IRQ high for exactly 1 cycle every 4 cycles over ≥3 periods; CTRL.Enable stays 1.
- CTRL=0x1 (IM=0), PRESET=2 → internal flag sets but IRQ=0. Then write CTRL=0x9 → reloads and next expiry raises IRQ=1.
- Mid-count: PRESET=10, counting, write PRESET=5 at COUNT=7 → continues 6,5,…; in Mode1 the next reload is 5. Clearing Enable at COUNT=4 → COUNT holds 4; re-enable → reload to 5.
- Assert reset at COUNT=3 in Mode1 → COUNT=0, IRQ=0 immediately. With TC_PRESCALE_EN, D=1, P=2 → IRQ period 6 cycles.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot or periodic interrupt.
// Optional prescaler on the count tick when TC_PRESCALE_EN is defined.
//
// state | meaning
// IDLE  | stopped; waits for CTRL.Enable
// LOAD  | copies PRESET into COUNT
// CNT   | decrements COUNT on each tick until it expires
// INT   | expiry cycle; reload (periodic) or disable (one-shot)
module timer_counter #(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        tick;
  logic [31:0] ctrl_rd;

  // The divisor field must fit in CTRL above the four control bits.
  if (PRESCALE_W < 1 || PRESCALE_W > 28) begin : g_bad_prescale_w
    $error("timer_counter: PRESCALE_W must be in 1..28");
  end

  assign wr_ctrl   = WE && (Addr == 2'd0);
  assign wr_preset = WE && (Addr == 2'd1);

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] ctrl_div;
  logic [PRESCALE_W-1:0] presc;

  assign tick = (presc == ctrl_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_div <= '0;
      presc    <= '0;
    end else begin
      if (wr_ctrl) ctrl_div <= Din[4 +: PRESCALE_W];
      if (state == CNT && ctrl_en) presc <= tick ? '0 : presc + 1'b1;
      else                         presc <= '0;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      // One-shot flag is acknowledged by any CTRL/PRESET write; a same-edge set below wins.
      if ((wr_ctrl || wr_preset) && ctrl_mode != 2'd1) irq_flag <= 1'b0;

      case (state)
        IDLE: if (ctrl_en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
        end
        INT: begin
          if (ctrl_mode == 2'd1) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl_en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Bus writes come last so they override the one-shot Enable clear.
      if (wr_ctrl) begin
        ctrl_en   <= Din[0];
        ctrl_mode <= Din[2:1];
        ctrl_im   <= Din[3];
      end
      if (wr_preset) preset <= Din;
    end
  end

  always_comb begin
    ctrl_rd      = '0;
    ctrl_rd[0]   = ctrl_en;
    ctrl_rd[2:1] = ctrl_mode;
    ctrl_rd[3]   = ctrl_im;
`ifdef TC_PRESCALE_EN
    ctrl_rd[4 +: PRESCALE_W] = ctrl_div;
`endif
    case (Addr)
      2'd0:    Dout = ctrl_rd;
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random bus traffic
// checked against a timeline model (load edge, expiry edge, tick arithmetic).
module tb_timer_counter;
  localparam int PW = 8;

  logic        clk;
  logic        reset;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec = 0;
  int n_err = 0;

  // Model: register image plus the edge numbers at which the timeline events occur.
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, load_p;
  int          m_div;
  longint      edge_no = 0;
  longint      load_edge, count_base, expire_edge, pulse_edge;
  bit          counting;

  timer_counter #(.PRESCALE_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait budget expired at edge %0d", tag, edge_no);
  endtask

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] v;
    v      = '0;
    v[0]   = m_en;
    v[2:1] = m_mode;
    v[3]   = m_im;
`ifdef TC_PRESCALE_EN
    v[4 +: PW] = m_div[PW-1:0];
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0; m_div = 0;
    m_preset = 0; m_count = 0; load_p = 0;
    load_edge = -1; count_base = -1; expire_edge = -1; pulse_edge = -1;
    counting = 0;
  endtask

  // Advance the model by one clock edge; a bus write is applied at that same edge.
  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [31:0] d);
    logic        en_o;
    logic [1:0]  mode_o;
    logic [31:0] pre_o;
    longint      steps;
    en_o = m_en; mode_o = m_mode; pre_o = m_preset;
    edge_no++;
    if (wr && (a == 2'd0 || a == 2'd1) && mode_o != 2'd1) m_flag = 0;
    if (load_edge == edge_no) begin
      load_p      = pre_o;
      m_count     = pre_o;
      count_base  = edge_no;
      steps       = (pre_o == 0) ? 1 : longint'(pre_o);
      expire_edge = edge_no + steps * (m_div + 1);
      counting    = 1;
      load_edge   = -1;
    end else if (counting) begin
      if (!en_o) begin
        counting = 0;
      end else if (edge_no >= expire_edge) begin
        m_count    = 0;
        m_flag     = 1;
        counting   = 0;
        pulse_edge = edge_no + 1;
      end else begin
        m_count = load_p - 32'((edge_no - count_base) / (m_div + 1));
      end
    end else if (pulse_edge == edge_no) begin
      pulse_edge = -1;
      if (mode_o == 2'd1) begin
        m_flag    = 0;
        load_edge = edge_no + 1;
      end else begin
        m_en = 0;
      end
    end else if (en_o) begin
      load_edge = edge_no + 1;
    end
    if (wr && a == 2'd0) begin
      m_en   = d[0];
      m_mode = d[2:1];
      m_im   = d[3];
`ifdef TC_PRESCALE_EN
      m_div  = int'(d[4 +: PW]);
`endif
    end
    if (wr && a == 2'd1) m_preset = d;
  endtask

  // Leaves Addr at COUNT so callers can read Dout as the count afterwards.
  task automatic check_all();
    Addr = 2'd0; #1 chk("ctrl", Dout, exp_ctrl());
    Addr = 2'd1; #1 chk("preset", Dout, m_preset);
    Addr = 2'd2; #1 chk("count", Dout, m_count);
    chk("irq", {31'b0, IRQ}, {31'b0, m_flag & m_im});
  endtask

  task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] d);
    WE = wr; Addr = a; Din = d;
    @(posedge clk);
    model_edge(wr, a, d);
    @(negedge clk);
    WE = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd2, 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    WE    = 1'b0;
    #1 model_reset();
    for (int a = 0; a < 4; a++) begin
      Addr = 2'(a);
      #1 chk("rst_dout", Dout, 32'd0);
    end
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
  endtask

  int seq_cnt [7] = '{0, 0, 3, 2, 1, 0, 0};
  int seq_irq [7] = '{0, 0, 0, 0, 0, 1, 1};

  initial begin
    int      pulses, doubles, last_hi, gap, prev_irq, p, div;
    bit      found;
    logic [31:0] d;

    reset = 1'b0; WE = 1'b0; Addr = 2'd0; Din = '0;

    // One-shot, PRESET=3: COUNT 3,2,1,0 at E2..E5, IRQ held, Enable auto-cleared.
    reset_dut();
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'h9);
    chk("os_cnt0", Dout, 32'(seq_cnt[0]));
    for (int i = 1; i < 7; i++) begin
      idle(1);
      chk("os_cnt", Dout, 32'(seq_cnt[i]));
      chk("os_irq", {31'b0, IRQ}, 32'(seq_irq[i]));
    end
    Addr = 2'd0; #1 chk("os_ctrl", Dout, 32'h8);
    cycle(1'b1, 2'd0, 32'h8);
    chk("os_ack", {31'b0, IRQ}, 32'd0);

    // Periodic, PRESET=2: one-cycle pulse every 4 cycles.
    reset_dut();
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'hB);
    pulses = 0; doubles = 0; last_hi = -1; gap = 0; prev_irq = 0;
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      if (IRQ) begin
        pulses++;
        if (prev_irq != 0) doubles++;
        if (last_hi >= 0) gap = i - last_hi;
        last_hi = i;
      end
      prev_irq = int'(IRQ);
    end
    chk("m1_pulses", 32'(pulses), 32'd4);
    chk("m1_width", 32'(doubles), 32'd0);
    chk("m1_period", 32'(gap), 32'd4);
    Addr = 2'd0; #1 chk("m1_en", {31'b0, Dout[0]}, 32'd1);

    // Masked interrupt, then unmask with a re-enable.
    reset_dut();
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'h1);
    idle(6);
    chk("im0_irq", {31'b0, IRQ}, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    idle(4);
    chk("im1_irq", {31'b0, IRQ}, 32'd1);

    // Mid-count PRESET change, reload from new value, pause and restart.
    reset_dut();
    cycle(1'b1, 2'd1, 32'd10);
    cycle(1'b1, 2'd0, 32'hB);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_count == 32'd7 && counting) found = 1;
      else idle(1);
    end
    if (!found) timeout("mid_wait7");
    cycle(1'b1, 2'd1, 32'd5);
    chk("mid_cont", Dout, 32'd6);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_flag) found = 1;
      else idle(1);
    end
    if (!found) timeout("mid_expire");
    idle(2);
    chk("mid_reload", Dout, 32'd5);
    cycle(1'b1, 2'd0, 32'hA);
    idle(3);
    chk("pause_hold", Dout, 32'd4);
    cycle(1'b1, 2'd0, 32'hB);
    idle(2);
    chk("resume_reload", Dout, 32'd5);

    // Reset asserted mid-count clears everything immediately.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_count == 32'd3 && counting) found = 1;
      else idle(1);
    end
    if (!found) timeout("rst_wait3");
    reset_dut();
    idle(12);
    chk("post_rst_irq", {31'b0, IRQ}, 32'd0);

`ifdef TC_PRESCALE_EN
    // Divisor 1, PRESET=2: period 2*(1+1)+2 = 6 cycles.
    reset_dut();
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'h1B);
    pulses = 0; last_hi = -1; gap = 0;
    for (int i = 1; i <= 24; i++) begin
      idle(1);
      if (IRQ) begin
        pulses++;
        if (last_hi >= 0) gap = i - last_hi;
        last_hi = i;
      end
    end
    chk("presc_pulses", 32'(pulses), 32'd4);
    chk("presc_period", 32'(gap), 32'd6);
`endif

    // Random episodes: any bus traffic, expectations from the timeline model.
    for (int ep = 0; ep < 30; ep++) begin
      reset_dut();
      p = $urandom_range(0, 6);
`ifdef TC_PRESCALE_EN
      div = $urandom_range(0, 2);
`else
      div = 0;
`endif
      cycle(1'b1, 2'd1, 32'(p));
      d = $urandom;
      d[0] = 1'b1;
`ifdef TC_PRESCALE_EN
      d[4 +: PW] = PW'(div);
`endif
      cycle(1'b1, 2'd0, d);
      for (int i = 0; i < 40; i++) begin
        int r;
        r = $urandom_range(0, 19);
        d = $urandom;
        if (r < 2) begin
`ifdef TC_PRESCALE_EN
          d[4 +: PW] = PW'(div);
`endif
          cycle(1'b1, 2'd0, d);
        end else if (r < 4) begin
          cycle(1'b1, 2'd1, 32'($urandom_range(0, 6)));
        end else if (r == 4) begin
          cycle(1'b1, 2'd2, d);
        end else if (r == 5) begin
          cycle(1'b1, 2'd3, d);
        end else begin
          cycle(1'b0, 2'($urandom_range(0, 3)), d);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
